uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Transmit end of the lab UART: accepts one byte per valid/ready handshake and drives it onto the serial line as 8N1 (start bit, 8 data bits LSB first, 1 stop bit).
- Bit timing comes from an internal free-running-while-busy counter, one bit period = CLKS_PER_BIT clocks. This matches the 25-clock sampling cadence used on the receive/input side.
- Sits between the lab's byte source (FSM or pushbutton logic) and the top-level TX pin.

Parameters:
- CLKS_PER_BIT, 25, clocks per serial bit; legal range is >= 2.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_valid  input  1  byte offered by the source.
- tx_data  input  DATA_BITS  byte to send; sampled only at handshake.
- tx_ready  output  1  high when a byte can be accepted (state IDLE).
- tx  output  1  serial line; idles high; registered.
- busy  output  1  high from the cycle after handshake through the end of the stop bit.
- tx_done  output  1  one-cycle pulse on the last clock of the stop bit.

Behaviour:
- Reset (async, rst_n=0): state IDLE, tx=1, busy=0, tx_done=0, bit counter=0, clock counter=0, shift register=0. tx_ready=1 once reset is released.
- tx_ready = (state==IDLE), combinational from state.
- Handshake: tx_valid && tx_ready at rising edge E latches tx_data into the shift register.
  - At that same edge: state goes to START, tx goes to 0, busy goes to 1.
  - tx_valid while not ready is ignored; the source must hold the byte.
- States and transitions:
  - IDLE: waits for handshake.
  - START: holds tx=0 for CLKS_PER_BIT clocks, then goes to DATA.
  - DATA: tx = shift[0]. Each bit is held for CLKS_PER_BIT clocks, then the register shifts right and the bit index increments. After bit index DATA_BITS-1 completes, goes to STOP.
  - STOP: tx=1 for CLKS_PER_BIT clocks.
    - On the last clock of STOP, tx_done=1.
    - Next edge: state IDLE, busy=0.
- Clock counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Held at 0 in IDLE.
- Bit index counter: width $clog2(DATA_BITS).
- Frame timing: tx low begins at edge E. Whole frame occupies exactly (DATA_BITS+2)*CLKS_PER_BIT clocks (250 at defaults). tx_ready returns high on the clock after the stop bit ends.
- Back-to-back: if tx_valid is held high, the next handshake occurs on the first IDLE cycle. Minimum spacing between start-bit falling edges is (DATA_BITS+2)*CLKS_PER_BIT + 1 clocks.
- tx_data changes while busy have no effect on the frame in flight.
- Reset mid-frame: tx returns to 1 immediately (asynchronous). No tx_done pulse. The partial frame is abandoned.
- tx is glitch-free: it is driven only from a flop, never combinationally from state.

Decomposition:
- Package uart_pkg holds:
  - the state enum tx_state_t {IDLE, START, DATA, STOP};
  - the localparam default CLKS_PER_BIT_DEFAULT = 25;
  - FRAME_BITS = DATA_BITS+2.
- One sub-module: uart_baud_gen.
  - Parameterized by CLKS_PER_BIT; enable input plus bit_tick output.
  - bit_tick is high on count==CLKS_PER_BIT-1.
  - Counter clears when enable is low.
  - Reusable by the receive side.

Test Plan:
- Reset: assert rst_n=0 mid-simulation → tx=1, busy=0, tx_ready=1 after release; no activity while tx_valid=0 for 500 clocks.
- Single byte 0xA5 at CLKS_PER_BIT=25:
  - Sampling tx at the middle of each 25-clock window gives 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - tx_done pulses at clock 250 after the handshake edge.
  - busy is high for exactly 250 clocks.
- Back-to-back 0x00 then 0xFF with tx_valid held: second start bit falls 251 clocks after the first. Frames decode to 0x00 and 0xFF.
- Data stability: change tx_data to 0x3C one clock after accepting 0x81 → the line still carries 0x81.
- Reset mid-frame: drop rst_n during data bit 3 → tx=1 in the same cycle, no tx_done. The next byte 0x55 transmits correctly after release.
- Parameter sweep: CLKS_PER_BIT=2 and DATA_BITS=8 with byte 0x96 → frame length 20 clocks, correct bit order.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the lab UART transmit/receive blocks
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam int CLKS_PER_BIT_DEFAULT = 25;
    localparam int DATA_BITS_DEFAULT    = 8;
    localparam int FRAME_BITS           = DATA_BITS_DEFAULT + 2;
endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte valid/ready handshake between a byte source and the serializer
interface uart_tx_serializer_if #(parameter int DATA_BITS = 8);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    modport master (output tx_valid, tx_data, input tx_ready);
    modport slave  (input tx_valid, tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter that runs while enabled and ticks on the last clock of each bit
module uart_baud_gen #(
    parameter  int CLKS_PER_BIT = 25,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic             bit_tick_o,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;

    assign bit_tick_o = count_q == CNT_W'(CLKS_PER_BIT - 1);
    assign count_o    = count_q;

    // wrap at each bit boundary, hold cleared while disabled
    always_comb count_d = (!en_i || bit_tick_o) ? '0 : count_q + 1'b1;

    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: accepts a byte per handshake and shifts it out as an 8N1 frame
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_serializer_if.slave    bus,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   tx_done_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_t            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 tx_q, busy_q, done_q;
    logic                 bit_tick;
    logic [CNT_W-1:0]     count;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q != IDLE),
        .bit_tick_o (bit_tick),
        .count_o    (count)
    );

    assign bus.tx_ready = state_q == IDLE;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign tx_done_o    = done_q;

    // frame sequencer; tx is loaded one edge ahead so the line only ever comes from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.tx_valid) begin
                    state_q <= START;
                    shift_q <= bus.tx_data;
                    idx_q   <= '0;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
                START: if (bit_tick) begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                end
                DATA: if (bit_tick) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + 1'b1;
                        tx_q    <= shift_q[1];
                    end
                end
                STOP: begin
                    done_q <= count == CNT_W'(CLKS_PER_BIT - 2);
                    if (bit_tick) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized and directed checks of the serializer against a frame-level model
module tb_uart_tx_serializer;
    import uart_pkg::*;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       valid = 0;
    logic [7:0] data = 0;
    bit         sel = 0;
    int         checks = 0, errors = 0, cyc = 0;
    logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b, prev_tx = 1;
    int         falls[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_tx_serializer_if #(.DATA_BITS(8)) if_a ();
    uart_tx_serializer_if #(.DATA_BITS(8)) if_b ();

    assign if_a.tx_valid = sel ? 1'b0 : valid;
    assign if_b.tx_valid = sel ? valid : 1'b0;
    assign if_a.tx_data  = data;
    assign if_b.tx_data  = data;

    uart_tx_serializer #(.CLKS_PER_BIT(25), .DATA_BITS(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .tx_o(tx_a), .busy_o(busy_a), .tx_done_o(done_a));
    uart_tx_serializer #(.CLKS_PER_BIT(2), .DATA_BITS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .tx_o(tx_b), .busy_o(busy_b), .tx_done_o(done_b));

    wire tx_m    = sel ? tx_b : tx_a;
    wire busy_m  = sel ? busy_b : busy_a;
    wire done_m  = sel ? done_b : done_a;
    wire ready_m = sel ? if_b.tx_ready : if_a.tx_ready;

    always @(negedge clk) begin
        if (prev_tx === 1'b1 && tx_m === 1'b0) falls.push_back(cyc);
        prev_tx <= tx_m;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one frame from the selected DUT, starting and ending at a negedge while idle
    task automatic send(input logic [7:0] d, input bit hold, input logic [7:0] nd);
        int cpb = sel ? 2 : 25;
        int n = FRAME_BITS * cpb;
        int bad_tx = 0, bad_busy = 0, bad_done = 0;
        logic [9:0] fr = {1'b1, d, 1'b0};
        logic [7:0] dec = 0;
        check("pre_ready", ready_m, 1);
        check("pre_busy", busy_m, 0);
        valid = 1;
        data  = d;
        @(posedge clk);
        #1;
        valid = hold;
        data  = nd;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (tx_m !== fr[k / cpb]) bad_tx++;
            if (busy_m !== 1'b1 || ready_m !== 1'b0) bad_busy++;
            if (done_m !== (k == n - 1)) bad_done++;
            if (k % cpb == cpb / 2 && k / cpb >= 1 && k / cpb <= 8) dec[k / cpb - 1] = tx_m;
        end
        check("tx_line", bad_tx, 0);
        check("busy_window", bad_busy, 0);
        check("done_pulse", bad_done, 0);
        check("decode", dec, d);
        @(negedge clk);
        check("post_busy", busy_m, 0);
        check("post_ready", ready_m, 1);
        check("post_tx", tx_m, 1);
    endtask

    initial begin
        int act;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        rst_n = 1;
        @(negedge clk);
        check("rst_ready", if_a.tx_ready, 1);
        act = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx_a !== 1 || busy_a !== 0 || done_a !== 0 || tx_b !== 1 || busy_b !== 0) act++;
        end
        check("idle_quiet", act, 0);

        rst_n = 0;
        #1;
        check("midsim_rst_tx", tx_a, 1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("midsim_rst_ready", if_a.tx_ready, 1);

        send(8'hA5, 0, 8'($urandom));

        falls.delete();
        send(8'h00, 1, 8'hFF);
        send(8'hFF, 0, 8'($urandom));
        check("b2b_falls", falls.size(), 2);
        if (falls.size() == 2) check("b2b_spacing", falls[1] - falls[0], 251);

        send(8'h81, 0, 8'h3C);

        valid = 1;
        data  = 8'hC3;
        @(posedge clk);
        #1;
        valid = 0;
        repeat (111) @(negedge clk);
        check("abort_in_frame", busy_a, 1);
        rst_n = 0;
        #1;
        check("abort_tx", tx_a, 1);
        check("abort_busy", busy_a, 0);
        act = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_a !== 0 || tx_a !== 1) act++;
        end
        check("abort_quiet", act, 0);
        rst_n = 1;
        @(negedge clk);
        send(8'h55, 0, 8'($urandom));

        sel = 1;
        send(8'h96, 0, 8'($urandom));

        for (int i = 0; i < 8; i++) begin
            sel = 1'($urandom);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            send(8'($urandom), 0, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
